// File: rtl/counter_load_sched.sv
// counter_load_sched: round-robin load/run/done sequencer for a shared counter; LDSCHED_TIMEOUT_EN adds a RUN timeout
module counter_load_sched #(
  parameter int WIDTH = 4,
  parameter logic [WIDTH-1:0] TERM_VALUE = 4'hF,
  parameter int TIMEOUT = 40
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             a_req_i,
  input  logic [WIDTH-1:0] a_value_i,
  output logic             a_gnt_o,
  output logic             a_done_o,
  input  logic             b_req_i,
  input  logic [WIDTH-1:0] b_value_i,
  output logic             b_gnt_o,
  output logic             b_done_o,
  output logic             ld_o,
  output logic [WIDTH-1:0] ld_value_o,
  input  logic [WIDTH-1:0] count_value_i,
  input  logic             count_valid_i,
  output logic             busy_o,
  output logic             owner_o,
  output logic             timeout_o
);
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
  state_t state, state_nx;
  logic ptr, ptr_nx, owner_nx, ld_nx, a_gnt_nx, b_gnt_nx, a_done_nx, b_done_nx, timeout_nx;
  logic term, expire, win;
  logic [WIDTH-1:0] ld_value_nx;
  assign term = count_valid_i && count_value_i == TERM_VALUE;
  assign win = a_req_i && b_req_i ? !ptr : b_req_i;
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("TIMEOUT must be >= 1");
  end
`ifdef LDSCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] timer;
  always_ff @(posedge clk_i)
    timer <= rst_i || state != RUN ? '0 : timer + 1'b1;
  assign expire = state == RUN && timer == TW'(TIMEOUT - 1);
`else
  assign expire = 1'b0;
`endif
  always_comb begin
    state_nx = state;
    ptr_nx = ptr;
    owner_nx = owner_o;
    ld_value_nx = ld_value_o;
    ld_nx = 1'b0;
    a_gnt_nx = 1'b0;
    b_gnt_nx = 1'b0;
    a_done_nx = 1'b0;
    b_done_nx = 1'b0;
    timeout_nx = 1'b0;
    case (state)
      IDLE: if (a_req_i || b_req_i) begin
        state_nx = LOAD;
        owner_nx = win;
        ld_value_nx = win ? b_value_i : a_value_i;
        ld_nx = 1'b1;
        a_gnt_nx = !win;
        b_gnt_nx = win;
      end
      LOAD: state_nx = RUN;
      RUN: if (term || expire) begin
        state_nx = DONE;
        a_done_nx = !owner_o;
        b_done_nx = owner_o;
        timeout_nx = !term;
      end
      default: begin
        state_nx = IDLE;
        ptr_nx = owner_o;
      end
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      ptr <= 1'b1;
      owner_o <= 1'b0;
      ld_value_o <= '0;
      ld_o <= 1'b0;
      a_gnt_o <= 1'b0;
      b_gnt_o <= 1'b0;
      a_done_o <= 1'b0;
      b_done_o <= 1'b0;
      timeout_o <= 1'b0;
      busy_o <= 1'b0;
    end else begin
      state <= state_nx;
      ptr <= ptr_nx;
      owner_o <= owner_nx;
      ld_value_o <= ld_value_nx;
      ld_o <= ld_nx;
      a_gnt_o <= a_gnt_nx;
      b_gnt_o <= b_gnt_nx;
      a_done_o <= a_done_nx;
      b_done_o <= b_done_nx;
      timeout_o <= timeout_nx;
      busy_o <= state_nx != IDLE;
    end
  end
endmodule
